// File: rtl/node_point_collector_pkg.sv
// rtl/node_point_collector_pkg.sv - mailbox addresses, node width and collector state encoding
package node_point_collector_pkg;

    localparam logic [31:0] START_ADDR = 32'h0200_0000;
    localparam logic [31:0] END_ADDR   = 32'h0200_0004;
    localparam logic [31:0] NODE_ADDR  = 32'h0200_0008;
    localparam logic [31:0] DONE_ADDR  = 32'h0200_000C;
    localparam int          NODE_W     = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/node_point_collector_fifo.sv
// rtl/node_point_collector_fifo.sv - first-word-fall-through node FIFO with occupancy count
module node_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_point_collector.sv
// rtl/node_point_collector.sv - decodes CPU mailbox writes into a node FIFO and tracks path completion
module node_point_collector #(
    parameter int          DEPTH     = 16,
    parameter int          NODE_W    = node_point_collector_pkg::NODE_W,
    parameter logic [31:0] NODE_ADDR = node_point_collector_pkg::NODE_ADDR,
    parameter logic [31:0] DONE_ADDR = node_point_collector_pkg::DONE_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     node_valid,
    output logic [NODE_W-1:0]        node_data,
    input  logic                     node_ready,
    output logic [$clog2(DEPTH):0]   node_count,
    output logic                     path_done,
    output logic                     overflow,
    output logic                     bad_node
);

    import node_point_collector_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t state;
    logic   node_wr;
    logic   done_wr;
    logic   upper_set;
    logic   push;
    logic   full;

    assign node_wr   = MemWrite && (DataAdr == NODE_ADDR);
    assign done_wr   = MemWrite && (DataAdr == DONE_ADDR) && (WriteData == 32'd1);
    assign upper_set = |WriteData[31:NODE_W];
    assign push      = node_wr && (state != DONE);
    assign full      = (node_count == FULL_COUNT);
    assign path_done = (state == DONE);

    node_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NODE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (node_ready),
        .wr_data (WriteData[NODE_W-1:0]),
        .rd_data (node_data),
        .valid   (node_valid),
        .count   (node_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            overflow <= 1'b0;
            bad_node <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_wr) begin
                        state <= DONE;
                    end else if (node_wr) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (done_wr) begin
                        state <= DONE;
                    end
                end
                default: state <= DONE;
            endcase
            if (push && full && !(node_ready && node_valid)) begin
                overflow <= 1'b1;
            end
            // Nodes after completion are dropped and flagged like malformed ones.
            if (node_wr && (upper_set || state == DONE)) begin
                bad_node <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_node_point_collector.sv
// tb/tb_node_point_collector.sv - directed checks of node_point_collector
module tb_node_point_collector;

    import node_point_collector_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        node_valid;
    logic [4:0]  node_data;
    logic        node_ready;
    logic [4:0]  node_count;
    logic        path_done;
    logic        overflow;
    logic        bad_node;

    int total = 0;
    int bad   = 0;

    node_point_collector dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .node_valid (node_valid),
        .node_data  (node_data),
        .node_ready (node_ready),
        .node_count (node_count),
        .path_done  (path_done),
        .overflow   (overflow),
        .bad_node   (bad_node)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus write across a single rising edge; returns at the following negedge.
    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic rdy);
        @(negedge clk);
        MemWrite   = 1'b1;
        DataAdr    = adr;
        WriteData  = dat;
        node_ready = rdy;
        @(negedge clk);
        MemWrite   = 1'b0;
        DataAdr    = 32'h0;
        WriteData  = 32'h0;
        node_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        MemWrite   = 1'b0;
        DataAdr    = 32'h0;
        WriteData  = 32'h0;
        node_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_valid", node_valid, 0);
        chk("rst_count", node_count, 0);
        chk("rst_data", node_data, 0);
        chk("rst_done", path_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bad", bad_node, 0);
        chk("rst_state", dut.state, IDLE);

        for (int i = 0; i < 4; i++) wr(NODE_ADDR, 32'(4 * i), 1'b0);
        chk("four_count", node_count, 4);
        chk("four_data", node_data, 0);
        chk("four_valid", node_valid, 1);
        chk("four_state", dut.state, COLLECT);

        node_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain4_data", node_data, 32'(4 * i));
            @(negedge clk);
        end
        chk("drain4_count", node_count, 0);
        chk("drain4_valid", node_valid, 0);
        chk("drain4_zero", node_data, 0);
        @(negedge clk);
        chk("empty_pop_count", node_count, 0);
        node_ready = 1'b0;

        wr(START_ADDR, 32'd9, 1'b0);
        chk("other_addr", node_count, 0);

        for (int i = 1; i <= 17; i++) wr(NODE_ADDR, 32'(i), 1'b0);
        chk("ovf_count", node_count, 16);
        chk("ovf_flag", overflow, 1);
        node_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_drain", node_data, 32'(i));
            @(negedge clk);
        end
        node_ready = 1'b0;
        chk("ovf_empty", node_valid, 0);

        do_reset();
        for (int i = 1; i <= 16; i++) wr(NODE_ADDR, 32'(i), 1'b0);
        chk("full_count", node_count, 16);
        wr(NODE_ADDR, 32'd20, 1'b1);
        chk("full_pp_count", node_count, 16);
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head", node_data, 2);
        node_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk("full_pp_drain", node_data, 32'(i));
            @(negedge clk);
        end
        chk("full_pp_tail", node_data, 20);
        @(negedge clk);
        node_ready = 1'b0;
        chk("full_pp_empty", node_count, 0);

        do_reset();
        wr(NODE_ADDR, 32'h0000_0025, 1'b0);
        chk("upper_bad", bad_node, 1);
        chk("upper_data", node_data, 5);
        node_ready = 1'b1;
        @(negedge clk);
        node_ready = 1'b0;

        do_reset();
        wr(NODE_ADDR, 32'd7, 1'b0);
        wr(DONE_ADDR, 32'd2, 1'b0);
        chk("done2_ignored", path_done, 0);
        wr(DONE_ADDR, 32'd1, 1'b0);
        chk("done1", path_done, 1);
        chk("done_keep_count", node_count, 1);
        chk("done_keep_data", node_data, 7);
        chk("done_bad_before", bad_node, 0);
        wr(NODE_ADDR, 32'd3, 1'b0);
        chk("done_drop_count", node_count, 1);
        chk("done_drop_bad", bad_node, 1);
        wr(NODE_ADDR, 32'd4, 1'b1);
        chk("done_drain", node_count, 0);
        chk("done_sticky", path_done, 1);

        do_reset();
        for (int i = 0; i < 3; i++) wr(NODE_ADDR, 32'(i + 10), 1'b0);
        chk("pre_rst_count", node_count, 3);
        @(negedge clk);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = NODE_ADDR;
        WriteData = 32'd6;
        @(negedge clk);
        reset     = 1'b0;
        MemWrite  = 1'b0;
        chk("mid_rst_count", node_count, 0);
        chk("mid_rst_valid", node_valid, 0);
        chk("mid_rst_data", node_data, 0);
        chk("mid_rst_state", dut.state, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
